// File: rtl/inst_loader.sv
// -----------------------------------------------------------------------------
// inst_loader
//
// Loads a program image into instruction memory from a byte stream.
// The stream carries a 16-bit little-endian word count followed by the words
// themselves, each sent least-significant byte first. Words are written to
// consecutive word addresses starting at 0. The CPU is held in stall until a
// complete image has been written.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a new load (pulse or level; ignored while busy)
//   in_data    in   stream byte
//   in_valid   in   in_data valid
//   in_ready   out  loader accepts a byte this cycle
//   mem_we     out  instruction-memory write strobe, one cycle per word
//   mem_addr   out  word address of the write (held between writes)
//   mem_wdata  out  word to write (held between writes)
//   cpu_hold   out  CPU must stall while high
//   busy       out  a load is in progress (header, data or final write)
//   done       out  one-cycle pulse when an image is complete
//   err        out  sticky: header word count exceeded memory depth
// -----------------------------------------------------------------------------
module inst_loader #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err
);

   // One extra bit so that DEPTH itself is representable for the compare.
   localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR0,
      S_HDR1,
      S_DATA,
      S_LAST,
      S_ERR
   } state_t;

   state_t              r_state;
   state_t              w_state_next;

   logic                r_in_ready;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [31:0]         r_mem_wdata;
   logic                r_cpu_hold;
   logic                r_busy;
   logic                r_done;
   logic                r_err;

   logic [7:0]          r_count_lo;   // low header byte, waits for the high byte
   logic [ADDR_W-1:0]   r_last_idx;   // count-1, index of the final word
   logic [ADDR_W-1:0]   r_word_idx;
   logic [1:0]          r_byte_idx;
   logic [23:0]         r_asm;        // bytes 0..2 of the word being assembled

   logic                w_xfer;
   logic                w_data_xfer;
   logic                w_word_end;
   logic                w_last_word;
   logic [15:0]         w_count;
   logic                w_complete;
   logic                w_load_start;
   logic                w_enter_err;
   logic [2:0]          w_lane_we;

   assign w_xfer       = in_valid && r_in_ready;
   assign w_data_xfer  = w_xfer && (r_state == S_DATA);
   assign w_word_end   = w_data_xfer && (r_byte_idx == 2'd3);
   assign w_last_word  = (r_word_idx == r_last_idx);
   assign w_count      = {in_data, r_count_lo};
   assign w_load_start = start && ((r_state == S_IDLE) || (r_state == S_ERR));
   assign w_enter_err  = (r_state == S_HDR1) && (w_state_next == S_ERR);

   // Byte-lane write enables for the first three bytes of a word; the fourth
   // byte goes straight from in_data into mem_wdata.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_lane
         assign w_lane_we[gi] = w_data_xfer && (r_byte_idx == 2'(gi));
      end
   endgenerate

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next state and completion detect
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_complete   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) w_state_next = S_HDR0;
         end
         S_HDR0: begin
            if (w_xfer) w_state_next = S_HDR1;
         end
         S_HDR1: begin
            if (w_xfer) begin
               if (w_count == 16'd0) begin
                  w_state_next = S_IDLE;
                  w_complete   = 1'b1;
               end else if ({1'b0, w_count} > DEPTH) begin
                  w_state_next = S_ERR;
               end else begin
                  w_state_next = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (w_word_end && w_last_word) w_state_next = S_LAST;
         end
         S_LAST: begin
            w_state_next = S_IDLE;
            w_complete   = 1'b1;
         end
         S_ERR: begin
            if (start) w_state_next = S_HDR0;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Registered outputs and datapath
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_in_ready  <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_cpu_hold  <= 1'b1;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_count_lo  <= '0;
         r_last_idx  <= '0;
         r_word_idx  <= '0;
         r_byte_idx  <= '0;
         r_asm       <= '0;
      end else begin
         // Output flags are decoded from the next state so they line up with
         // the state they describe.
         r_in_ready <= (w_state_next == S_HDR0) || (w_state_next == S_HDR1) ||
                       (w_state_next == S_DATA);
         r_busy     <= (w_state_next == S_HDR0) || (w_state_next == S_HDR1) ||
                       (w_state_next == S_DATA) || (w_state_next == S_LAST);
         r_done     <= w_complete;
         r_mem_we   <= w_word_end;

         if (w_word_end) begin
            r_mem_addr  <= r_word_idx;
            r_mem_wdata <= {in_data, r_asm};
         end

         if (w_complete) begin
            r_cpu_hold <= 1'b0;
         end else if (w_load_start) begin
            r_cpu_hold <= 1'b1;
         end

         if (w_load_start) begin
            r_err <= 1'b0;
         end else if (w_enter_err) begin
            r_err <= 1'b1;
         end

         if ((r_state == S_HDR0) && w_xfer) begin
            r_count_lo <= in_data;
         end

         // Header complete: address restarts at 0 for every load.
         if ((r_state == S_HDR1) && w_xfer) begin
            r_last_idx <= ADDR_W'(w_count - 16'd1);
            r_word_idx <= '0;
            r_byte_idx <= '0;
         end

         if (w_data_xfer) begin
            r_byte_idx <= r_byte_idx + 2'd1;
            // The index stops on the final word, so count==DEPTH never wraps.
            if (w_word_end && !w_last_word) begin
               r_word_idx <= r_word_idx + 1'b1;
            end
         end

         for (int b = 0; b < 3; b++) begin
            if (w_lane_we[b]) r_asm[b*8 +: 8] <= in_data;
         end
      end
   end

   assign in_ready  = r_in_ready;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign cpu_hold  = r_cpu_hold;
   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;

endmodule

// File: tb/tb_inst_loader.sv
// -----------------------------------------------------------------------------
// tb_inst_loader
//
// Two loaders (1024-word and 4-word) share one stimulus stream. A byte-count
// reference model per instance predicts every output each cycle; a memory
// image built from the model is compared against the image built from the
// DUT write port at the end.
// -----------------------------------------------------------------------------
module tb_inst_loader;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;

   logic        rdy  [2];
   logic        we   [2];
   logic        hold [2];
   logic        bsy  [2];
   logic        dn   [2];
   logic        er   [2];
   logic [31:0] wd   [2];
   logic [9:0]  b_addr;
   logic [1:0]  s_addr;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   inst_loader #(.ADDR_W(10)) u_big (
      .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
      .in_valid(in_valid), .in_ready(rdy[0]), .mem_we(we[0]),
      .mem_addr(b_addr), .mem_wdata(wd[0]), .cpu_hold(hold[0]),
      .busy(bsy[0]), .done(dn[0]), .err(er[0])
   );

   inst_loader #(.ADDR_W(2)) u_small (
      .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
      .in_valid(in_valid), .in_ready(rdy[1]), .mem_we(we[1]),
      .mem_addr(s_addr), .mem_wdata(wd[1]), .cpu_hold(hold[1]),
      .busy(bsy[1]), .done(dn[1]), .err(er[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: tracks bytes received in the current image.
   // ---------------------------------------------------------------------------
   int          m_depth [2] = '{1024, 4};
   bit          m_loading [2];
   bit          m_tail [2];     // final word written, completion due next edge
   bit          m_err [2];
   bit          m_hold [2];
   bit          m_done [2];
   bit          m_we [2];
   int          m_n [2];
   int          m_cnt [2];
   logic [9:0]  m_addr [2];
   logic [31:0] m_data [2];
   logic [7:0]  m_buf [2][4];
   logic [31:0] m_mem [2][1024];
   logic [31:0] d_mem [2][1024];
   int          nwr [2];
   int          ndone [2];
   int          done_cyc [2];
   int          last_acc;

   task automatic mreset(input int i);
      m_loading[i] = 0; m_tail[i] = 0; m_err[i] = 0; m_hold[i] = 1;
      m_done[i] = 0; m_we[i] = 0; m_n[i] = 0; m_cnt[i] = 0;
      m_addr[i] = '0; m_data[i] = '0;
   endtask

   task automatic mstep(input int i);
      bit acc;
      int k;
      acc = m_loading[i] && !m_tail[i] && in_valid;
      m_done[i] = 0;
      m_we[i]   = 0;
      if (m_tail[i]) begin
         m_tail[i] = 0; m_loading[i] = 0; m_done[i] = 1; m_hold[i] = 0;
      end else if (!m_loading[i]) begin
         if (start) begin
            m_loading[i] = 1; m_n[i] = 0; m_hold[i] = 1; m_err[i] = 0;
         end
      end else if (acc) begin
         if (m_n[i] == 0) begin
            m_cnt[i] = int'(in_data);
         end else if (m_n[i] == 1) begin
            m_cnt[i] = m_cnt[i] + (int'(in_data) << 8);
            if (m_cnt[i] == 0) begin
               m_loading[i] = 0; m_done[i] = 1; m_hold[i] = 0;
            end else if (m_cnt[i] > m_depth[i]) begin
               m_loading[i] = 0; m_err[i] = 1;
            end
         end else begin
            k = m_n[i] - 2;
            m_buf[i][k % 4] = in_data;
            if (k % 4 == 3) begin
               m_we[i]   = 1;
               m_addr[i] = 10'(k / 4);
               m_data[i] = {m_buf[i][3], m_buf[i][2], m_buf[i][1], m_buf[i][0]};
               m_mem[i][k / 4] = m_data[i];
               if (k / 4 == m_cnt[i] - 1) m_tail[i] = 1;
            end
         end
         m_n[i]++;
      end
   endtask

   initial begin
      for (int i = 0; i < 2; i++) mreset(i);
      forever begin
         @(posedge clk or negedge rst_n);
         for (int i = 0; i < 2; i++) begin
            if (!rst_n) mreset(i);
            else        mstep(i);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Per-cycle compare, away from the active edge.
   // ---------------------------------------------------------------------------
   initial forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         logic [9:0] a;
         a = (i == 0) ? b_addr : {8'd0, s_addr};
         chk($sformatf("in_ready[%0d]", i),  32'(rdy[i]),  32'(m_loading[i] && !m_tail[i]));
         chk($sformatf("mem_we[%0d]", i),    32'(we[i]),   32'(m_we[i]));
         chk($sformatf("mem_addr[%0d]", i),  32'(a),       32'(m_addr[i]));
         chk($sformatf("mem_wdata[%0d]", i), wd[i],        m_data[i]);
         chk($sformatf("cpu_hold[%0d]", i),  32'(hold[i]), 32'(m_hold[i]));
         chk($sformatf("busy[%0d]", i),      32'(bsy[i]),  32'(m_loading[i]));
         chk($sformatf("done[%0d]", i),      32'(dn[i]),   32'(m_done[i]));
         chk($sformatf("err[%0d]", i),       32'(er[i]),   32'(m_err[i]));
         if (we[i] === 1'b1) begin
            d_mem[i][a] = wd[i];
            nwr[i]++;
         end
         if (dn[i] === 1'b1) begin
            ndone[i]++;
            done_cyc[i] = cyc;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus tasks (called at posedge+1)
   // ---------------------------------------------------------------------------
   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Present a byte until the large loader (per the model) takes it, then
   // optionally idle the bus with junk data for up to gap_max cycles.
   task automatic put_byte(input logic [7:0] b, input int gap_max);
      int  n;
      bit  r;
      int  g;
      n = 0;
      in_valid = 1'b1;
      in_data  = b;
      forever begin
         r = m_loading[0] && !m_tail[0];
         @(posedge clk); #1;
         if (r) break;
         n++;
         if (n > 40) begin
            total++; bad++;
            $display("FAIL byte_accept_timeout actual=none required=accept (cycle %0d)", cyc);
            break;
         end
      end
      last_acc = cyc;
      g = $urandom_range(0, gap_max);
      if (g > 0) begin
         in_valid = 1'b0;
         in_data  = 8'($urandom);
         repeat (g) begin @(posedge clk); #1; end
      end
   endtask

   task automatic send_hdr(input int cnt, input int gap);
      logic [15:0] c;
      c = 16'(cnt);
      put_byte(c[7:0], gap);
      put_byte(c[15:8], gap);
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int j = 0; j < 4; j++) put_byte(w[8*j +: 8], gap);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      in_valid = 1'b0;
      while ((m_loading[0] || m_loading[1]) && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      if (m_loading[0] || m_loading[1]) begin
         total++; bad++;
         $display("FAIL idle_timeout actual=busy required=idle (cycle %0d)", cyc);
      end
      repeat (2) begin @(posedge clk); #1; end
   endtask

   // ---------------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------------
   initial begin
      int w0, d0, w1, cnt, mism;
      logic [31:0] rw;

      for (int i = 0; i < 2; i++) begin
         for (int a = 0; a < 1024; a++) begin
            m_mem[i][a] = '0;
            d_mem[i][a] = '0;
         end
         nwr[i] = 0; ndone[i] = 0; done_cyc[i] = 0;
      end
      rst_n = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_cpu_hold", 32'(hold[0]), 32'd1);
      chk("reset_in_ready", 32'(rdy[0]),  32'd0);
      chk("reset_mem_addr", 32'(b_addr),  32'd0);
      chk("reset_err",      32'(er[0]),   32'd0);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      // Two-word image at one byte per cycle.
      w0 = nwr[0]; d0 = ndone[0];
      pulse_start();
      send_hdr(2, 0);
      send_word(32'h12345678, 0);
      send_word(32'hDEADBEEF, 0);
      w1 = last_acc;
      wait_idle();
      chk("img1_word0",  d_mem[0][0], 32'h12345678);
      chk("img1_word1",  d_mem[0][1], 32'hDEADBEEF);
      chk("img1_writes", 32'(nwr[0] - w0), 32'd2);
      chk("img1_done",   32'(ndone[0] - d0), 32'd1);
      // Last byte taken at edge E: mem_we follows E, done follows E+1.
      chk("img1_done_lag", 32'(done_cyc[0] - w1), 32'd1);
      chk("img1_hold_low", 32'(hold[0]), 32'd0);

      // Same image with random bubbles on in_valid.
      w0 = nwr[0];
      pulse_start();
      send_hdr(2, 3);
      send_word(32'h12345678, 3);
      send_word(32'hDEADBEEF, 3);
      wait_idle();
      chk("img2_word0",  d_mem[0][0], 32'h12345678);
      chk("img2_word1",  d_mem[0][1], 32'hDEADBEEF);
      chk("img2_writes", 32'(nwr[0] - w0), 32'd2);

      // Empty image.
      w0 = nwr[0]; d0 = ndone[0];
      pulse_start();
      send_hdr(0, 0);
      w1 = last_acc;
      wait_idle();
      chk("empty_writes",    32'(nwr[0] - w0), 32'd0);
      chk("empty_done",      32'(ndone[0] - d0), 32'd1);
      chk("empty_done_lag",  32'(done_cyc[0] - w1), 32'd0);
      chk("empty_hold_low",  32'(hold[0]), 32'd0);

      // Oversized header for the 4-word loader, then a full-depth load.
      w0 = nwr[1];
      pulse_start();
      send_hdr(5, 0);
      for (int j = 0; j < 5; j++) send_word(32'hA0000000 + 32'(j), 0);
      wait_idle();
      chk("ovf_err",      32'(er[1]),   32'd1);
      chk("ovf_hold",     32'(hold[1]), 32'd1);
      chk("ovf_ready",    32'(rdy[1]),  32'd0);
      chk("ovf_writes",   32'(nwr[1] - w0), 32'd0);
      w0 = nwr[1]; d0 = ndone[1];
      pulse_start();
      send_hdr(4, 1);
      for (int j = 0; j < 4; j++) send_word(32'hB0B00000 + 32'(j * 17), 1);
      wait_idle();
      chk("full_err_clr", 32'(er[1]), 32'd0);
      chk("full_writes",  32'(nwr[1] - w0), 32'd4);
      chk("full_done",    32'(ndone[1] - d0), 32'd1);
      chk("full_addr3",   d_mem[1][3], 32'hB0B00033);
      chk("full_addr0",   d_mem[1][0], 32'hB0B00000);

      // start held high during DATA is ignored.
      w0 = nwr[0]; d0 = ndone[0];
      pulse_start();
      send_hdr(3, 0);
      send_word(32'h01020304, 0);
      start = 1'b1;
      send_word(32'h05060708, 0);
      start = 1'b0;
      send_word(32'h090A0B0C, 0);
      wait_idle();
      chk("restart_ign_writes", 32'(nwr[0] - w0), 32'd3);
      chk("restart_ign_done",   32'(ndone[0] - d0), 32'd1);
      chk("restart_ign_word2",  d_mem[0][2], 32'h090A0B0C);

      // Randomized images.
      for (int r = 0; r < 6; r++) begin
         cnt = $urandom_range(1, 6);
         pulse_start();
         send_hdr(cnt, 2);
         for (int j = 0; j < cnt; j++) begin
            rw = $urandom;
            send_word(rw, 2);
         end
         wait_idle();
      end

      // Reset after the second byte of word 1.
      w0 = nwr[0];
      pulse_start();
      send_hdr(2, 0);
      send_word(32'h11223344, 0);
      put_byte(8'h55, 0);
      put_byte(8'h66, 0);
      in_valid = 1'b0;
      #3 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("midrst_we",     32'(we[0]),   32'd0);
      chk("midrst_hold",   32'(hold[0]), 32'd1);
      chk("midrst_busy",   32'(bsy[0]),  32'd0);
      chk("midrst_writes", 32'(nwr[0] - w0), 32'd1);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      pulse_start();
      send_hdr(1, 0);
      send_word(32'hCAFEF00D, 0);
      wait_idle();
      chk("postrst_addr0",  d_mem[0][0], 32'hCAFEF00D);
      chk("postrst_writes", 32'(nwr[0] - w0), 32'd2);

      for (int i = 0; i < 2; i++) begin
         mism = 0;
         for (int a = 0; a < 1024; a++) begin
            if (d_mem[i][a] !== m_mem[i][a]) mism++;
         end
         chk($sformatf("mem_image[%0d]", i), 32'(mism), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
